// File: rtl/layer_4_window_buffer_pkg.sv
// Shared constants for the layer-3 pool / layer-4 window stages.
// Also holds the window-buffer state encoding.
package layer_4_window_buffer_pkg;

   localparam int L4_DATA_W     = 8;
   localparam int L4_FM_SIZE    = 12;
   localparam int L4_K_SIZE     = 3;
   localparam int L4_ADDR_W     = 8;
   localparam int L4_OUT_SIZE   = L4_FM_SIZE - L4_K_SIZE + 1;
   localparam int L4_FM_PIXELS  = L4_FM_SIZE * L4_FM_SIZE;
   localparam int L4_WIN_PIXELS = L4_OUT_SIZE * L4_OUT_SIZE * L4_K_SIZE * L4_K_SIZE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01
   } state_t;

endpackage

// File: rtl/layer_4_window_buffer_skid.sv
// Two-entry valid/ready skid buffer; entry 0 drives the output registers.
// Absorbs the one-cycle RAM read latency while the consumer stalls.
module fm_skid_buffer #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       count
);

   logic             v0, v1;
   logic [WIDTH-1:0] d0, d1;
   logic             pop;

   assign pop       = v0 && out_ready;
   assign out_valid = v0;
   assign out_data  = d0;
   assign count     = {1'b0, v0} + {1'b0, v1};

   always_ff @(posedge clk) begin
      if (!rst) begin
         v0 <= 1'b0;
         v1 <= 1'b0;
         d0 <= '0;
         d1 <= '0;
      end else begin
         case ({in_valid, pop})
            2'b10: begin
               if (!v0) begin
                  d0 <= in_data;
                  v0 <= 1'b1;
               end else begin
                  d1 <= in_data;
                  v1 <= 1'b1;
               end
            end
            2'b01: begin
               d0 <= d1;
               v0 <= v1;
               v1 <= 1'b0;
            end
            2'b11: begin
               // Entry 1 shifts forward and the new word takes its place.
               if (v1) begin
                  d0 <= d1;
                  d1 <= in_data;
               end else begin
                  d0 <= in_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/layer_4_window_buffer.sv
// Captures the pooled 12x12 map into RAM and replays it as 3x3 valid windows,
// starting each window row as soon as the input rows it needs are written.
module layer_4_window_buffer
   import layer_4_window_buffer_pkg::*;
#(
   parameter int DATA_W  = L4_DATA_W,
   parameter int FM_SIZE = L4_FM_SIZE,
   parameter int K_SIZE  = L4_K_SIZE,
   parameter int ADDR_W  = L4_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              layer_4_begin,
   input  logic [DATA_W-1:0] d_in,
   input  logic              relu_3_ready,
   output logic [DATA_W-1:0] pix_out,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_first,
   output logic              pix_last,
   output logic              fill_complete,
   output logic              layer_4_complete
);

   localparam int OUT_SIZE  = FM_SIZE - K_SIZE + 1;
   localparam int FM_PIXELS = FM_SIZE * FM_SIZE;
   localparam int CNT_W     = ADDR_W + 1;
   localparam int OW        = $clog2(OUT_SIZE);
   localparam int KW        = $clog2(K_SIZE);

   localparam logic [CNT_W-1:0]  FM_PIX_C   = CNT_W'(FM_PIXELS);
   localparam logic [CNT_W-1:0]  GATE_INIT  = CNT_W'(K_SIZE * FM_SIZE);
   localparam logic [CNT_W-1:0]  GATE_STEP  = CNT_W'(FM_SIZE);
   localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(FM_SIZE - K_SIZE + 1);
   localparam logic [ADDR_W-1:0] WRAP_STEP  = ADDR_W'(K_SIZE);
   localparam logic [OW-1:0]     OUT_LAST   = OW'(OUT_SIZE - 1);
   localparam logic [KW-1:0]     K_LAST     = KW'(K_SIZE - 1);

   state_t            state;
   logic [CNT_W-1:0]  wr_cnt;
   logic [CNT_W-1:0]  gate_thr;
   logic [OW-1:0]     out_r, out_c;
   logic [KW-1:0]     k_r, k_c;
   logic [ADDR_W-1:0] rd_addr, win_base;
   logic              rd_done;

   logic [DATA_W-1:0] mem [FM_PIXELS];
   logic [DATA_W-1:0] rd_data;
   logic              rd_vld, rd_first, rd_last;

   logic              wr_en, issue, pop, last_pop, space_ok;
   logic [1:0]        skid_cnt;
   logic [2:0]        occ_next;

   assign wr_en    = (state == ST_RUN) && relu_3_ready && (wr_cnt < FM_PIX_C);
   assign pop      = pix_valid && pix_ready;
   // Occupancy after this cycle's push/pop; the new issue lands one cycle later.
   assign occ_next = {1'b0, skid_cnt} + {2'b00, rd_vld} - {2'b00, pop};
   assign space_ok = occ_next < 3'd2;
   assign issue    = (state == ST_RUN) && !rd_done && (wr_cnt >= gate_thr) && space_ok;
   assign last_pop = pop && rd_done && !rd_vld && (skid_cnt == 2'd1);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_cnt[ADDR_W-1:0]] <= d_in;
      if (issue) rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= ST_IDLE;
         wr_cnt           <= '0;
         gate_thr         <= GATE_INIT;
         out_r            <= '0;
         out_c            <= '0;
         k_r              <= '0;
         k_c              <= '0;
         rd_addr          <= '0;
         win_base         <= '0;
         rd_done          <= 1'b0;
         rd_vld           <= 1'b0;
         rd_first         <= 1'b0;
         rd_last          <= 1'b0;
         fill_complete    <= 1'b0;
         layer_4_complete <= 1'b0;
      end else begin
         fill_complete    <= 1'b0;
         layer_4_complete <= 1'b0;
         rd_vld           <= issue;
         rd_first         <= issue && (k_r == '0) && (k_c == '0);
         rd_last          <= issue && (k_r == K_LAST) && (k_c == K_LAST);
         case (state)
            ST_IDLE: begin
               if (layer_4_begin) begin
                  state    <= ST_RUN;
                  wr_cnt   <= '0;
                  gate_thr <= GATE_INIT;
                  out_r    <= '0;
                  out_c    <= '0;
                  k_r      <= '0;
                  k_c      <= '0;
                  rd_addr  <= '0;
                  win_base <= '0;
                  rd_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (wr_en) begin
                  wr_cnt <= wr_cnt + 1'b1;
                  if (wr_cnt == FM_PIX_C - 1'b1) fill_complete <= 1'b1;
               end
               if (issue) begin
                  // Address walks by deltas: +1 along a kernel row, +ROW_STEP to the
                  // next kernel row, then back to the next window base.
                  if (k_c != K_LAST) begin
                     k_c     <= k_c + 1'b1;
                     rd_addr <= rd_addr + 1'b1;
                  end else if (k_r != K_LAST) begin
                     k_c     <= '0;
                     k_r     <= k_r + 1'b1;
                     rd_addr <= rd_addr + ROW_STEP;
                  end else begin
                     k_c <= '0;
                     k_r <= '0;
                     if (out_c != OUT_LAST) begin
                        out_c    <= out_c + 1'b1;
                        win_base <= win_base + 1'b1;
                        rd_addr  <= win_base + 1'b1;
                     end else if (out_r != OUT_LAST) begin
                        out_c    <= '0;
                        out_r    <= out_r + 1'b1;
                        win_base <= win_base + WRAP_STEP;
                        rd_addr  <= win_base + WRAP_STEP;
                        gate_thr <= gate_thr + GATE_STEP;
                     end else begin
                        rd_done <= 1'b1;
                     end
                  end
               end
               if (last_pop) begin
                  layer_4_complete <= 1'b1;
                  state            <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   fm_skid_buffer #(
      .WIDTH(DATA_W + 2)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (rd_vld),
      .in_data  ({rd_data, rd_first, rd_last}),
      .out_valid(pix_valid),
      .out_data ({pix_out, pix_first, pix_last}),
      .out_ready(pix_ready),
      .count    (skid_cnt)
   );

endmodule

// File: tb/tb_layer_4_window_buffer.sv
// Bench for layer_4_window_buffer: random/ramp frames scored against an image
// array and window arithmetic, with backpressure, spurious inputs and mid-run reset.
module tb_layer_4_window_buffer;
   import layer_4_window_buffer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       layer_4_begin = 1'b0;
   logic       relu_3_ready = 1'b0;
   logic       pix_ready = 1'b0;
   logic [7:0] d_in = '0;
   logic [7:0] pix_out;
   logic       pix_valid, pix_first, pix_last, fill_complete, layer_4_complete;

   int n_vec = 0, n_err = 0;
   int ready_pct = 100;
   int frame_id = 0, frame_seen = 0, end_seq = 0, end_seen = 0;
   int hs_idx = 0, n_fill = 0, n_done = 0, wcnt = 0;
   int r, c, kr, kc;
   bit gate_seen = 0, prev_stall = 0;
   logic [9:0] prev_word = '0;
   logic rst_seen = 1'b1;
   logic [7:0] img [L4_FM_PIXELS];

   localparam int PER_ROW = L4_OUT_SIZE * L4_K_SIZE * L4_K_SIZE;
   localparam int PER_WIN = L4_K_SIZE * L4_K_SIZE;

   always #5 clk = ~clk;

   layer_4_window_buffer #(
      .DATA_W (L4_DATA_W),
      .FM_SIZE(L4_FM_SIZE),
      .K_SIZE (L4_K_SIZE),
      .ADDR_W (L4_ADDR_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .layer_4_begin   (layer_4_begin),
      .d_in            (d_in),
      .relu_3_ready    (relu_3_ready),
      .pix_out         (pix_out),
      .pix_valid       (pix_valid),
      .pix_ready       (pix_ready),
      .pix_first       (pix_first),
      .pix_last        (pix_last),
      .fill_complete   (fill_complete),
      .layer_4_complete(layer_4_complete)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) rst_seen <= rst;

   always @(posedge clk) begin
      #1 pix_ready = ($urandom_range(99) < ready_pct);
   end

   always @(negedge clk) begin
      if (!rst_seen) begin
         check("rst_outs", {pix_out, pix_valid, pix_first, pix_last, fill_complete, layer_4_complete}, 0);
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", pix_valid, 1);
            check("hold_data", {pix_out, pix_first, pix_last}, prev_word);
         end
         if (pix_valid === 1'b1 && !gate_seen) begin
            gate_seen = 1;
            check("gate_36", wcnt >= 3 * L4_FM_SIZE, 1);
         end
         if (pix_valid === 1'b1 && pix_ready) begin
            if (hs_idx >= L4_WIN_PIXELS) begin
               check("extra_hs", hs_idx, L4_WIN_PIXELS - 1);
            end else begin
               r  = hs_idx / PER_ROW;
               c  = (hs_idx % PER_ROW) / PER_WIN;
               kr = (hs_idx % PER_WIN) / L4_K_SIZE;
               kc = hs_idx % L4_K_SIZE;
               check("pix", pix_out, img[(r + kr) * L4_FM_SIZE + c + kc]);
               check("first", pix_first, (kr == 0 && kc == 0));
               check("last", pix_last, (kr == L4_K_SIZE - 1 && kc == L4_K_SIZE - 1));
               if (hs_idx == PER_ROW) check("row1_gate", wcnt >= 4 * L4_FM_SIZE, 1);
               hs_idx++;
            end
         end
         if (fill_complete) n_fill++;
         if (layer_4_complete) begin
            n_done++;
            check("done_at", hs_idx, L4_WIN_PIXELS);
         end
         prev_stall = (pix_valid === 1'b1) && !pix_ready;
         prev_word  = {pix_out, pix_first, pix_last};
      end
      if (end_seq != end_seen) begin
         end_seen = end_seq;
         check("hs_total", hs_idx, L4_WIN_PIXELS);
         check("fill_pulses", n_fill, 1);
         check("done_pulses", n_done, 1);
      end
      if (frame_id != frame_seen) begin
         frame_seen = frame_id;
         hs_idx     = 0;
         n_fill     = 0;
         n_done     = 0;
         gate_seen  = 0;
         prev_stall = 0;
      end
   end

   task automatic idle_strobes(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         relu_3_ready = 1'b1;
         d_in = 8'($urandom_range(255));
      end
      @(posedge clk);
      #1 relu_3_ready = 1'b0;
   endtask

   // kind: 0 ramp, 1 inverted ramp, 2 random. abort_at>0 returns early after that many handshakes.
   task automatic run_frame(input int kind, input int n_str, input int rdy, input int spur_cyc,
                            input int abort_at);
      int k = 0;
      @(negedge clk);
      @(posedge clk);
      #1;
      frame_id++;
      wcnt = 0;
      ready_pct = rdy;
      for (int i = 0; i < L4_FM_PIXELS; i++)
         img[i] = (kind == 0) ? 8'(i) : (kind == 1) ? 8'(255 - i) : 8'($urandom_range(255));
      layer_4_begin = 1'b1;
      @(posedge clk);
      #1 layer_4_begin = 1'b0;
      for (int cyc = 0; cyc < 8000; cyc++) begin
         layer_4_begin = (cyc == spur_cyc);
         if (cyc % 4 == 0 && k < n_str) begin
            relu_3_ready = 1'b1;
            d_in = (k < L4_FM_PIXELS) ? img[k] : 8'($urandom_range(255));
            k++;
         end else begin
            relu_3_ready = 1'b0;
         end
         @(posedge clk);
         if (relu_3_ready) wcnt++;
         #1;
         relu_3_ready  = 1'b0;
         layer_4_begin = 1'b0;
         if (layer_4_complete) begin
            end_seq++;
            return;
         end
         if (abort_at > 0 && hs_idx >= abort_at) return;
      end
      end_seq++;
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      idle_strobes(5);
      run_frame(0, 144, 100, -1, 0);
      run_frame(0, 144, 30, -1, 0);
      idle_strobes(4);
      run_frame(0, 150, 100, 200, 0);
      run_frame(2, 144, 70, -1, 500);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      run_frame(0, 144, 100, -1, 0);
      run_frame(0, 144, 100, -1, 0);
      run_frame(1, 144, 100, -1, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
